// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared types and constants for the ioctl download router
package ioctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dn_state_t;

  localparam int ERR_OVERFLOW = 2;
  localparam int ERR_ADDR     = 1;
  localparam int ERR_INDEX    = 0;

  localparam int IOCTL_ADDR_W = 25;

  // Width of a target index field; a single target still needs one bit of storage
  function automatic int tgt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered head output and occupancy count
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);

  // Occupancy after this cycle's push/pop, used to decide what the head register shows next
  always_comb begin
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage array; no reset needed because the head register gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count and the registered head; the head bypasses din when the new head is being written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) begin
        if (do_push && (rd_ptr_nxt == wr_ptr)) begin
          dout <= din;
        end else begin
          dout <= mem[rd_ptr_nxt];
        end
      end
    end
  end

endmodule

// File: rtl/ioctl_dn_router.sv
// rtl/ioctl_dn_router.sv - buffers the ioctl byte stream and routes it to per-index download ports
module ioctl_dn_router
  import ioctl_pkg::*;
#(
  parameter int NUM_TARGETS = 2,
  parameter int ADDR_W      = 14,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_THRESH = 6
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  input  logic [7:0]              ioctl_index,
  output logic                    ioctl_wait,
  output logic [ADDR_W-1:0]       dn_addr,
  output logic [7:0]              dn_data,
  output logic [NUM_TARGETS-1:0]  dn_wr,
  input  logic [NUM_TARGETS-1:0]  dn_ready,
  output logic                    dn_active,
  output logic                    dn_done,
  output logic [IOCTL_ADDR_W-1:0] dn_count,
  output logic [2:0]              dn_err
);

  localparam int TGT_W   = tgt_width(NUM_TARGETS);
  localparam int ENTRY_W = TGT_W + ADDR_W + 8;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  dn_state_t          state;
  dn_state_t          state_nxt;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   occ_nxt;
  logic               fifo_empty;
  logic               fifo_full;
  logic [TGT_W-1:0]   head_tgt;
  logic               wr_load;
  logic               idx_ok;
  logic               addr_ok;
  logic               room_ok;
  logic               push_ok;
  logic               pop;

  // Qualification of an incoming byte; writes outside LOAD are ignored entirely
  assign wr_load  = (state == LOAD) && ioctl_wr;
  assign idx_ok   = (ioctl_index < 8'(NUM_TARGETS));
  assign addr_ok  = ((ioctl_addr >> ADDR_W) == '0);
  assign room_ok  = !fifo_full || pop;
  assign push_ok  = wr_load && idx_ok && addr_ok && room_ok;
  assign fifo_din = {ioctl_index[TGT_W-1:0], ioctl_addr[ADDR_W-1:0], ioctl_dout};

  // Head fields come straight from the FIFO's registered head, so dn_* never depend on dn_ready
  assign head_tgt = fifo_dout[ENTRY_W-1 -: TGT_W];
  assign dn_addr  = fifo_dout[8 +: ADDR_W];
  assign dn_data  = fifo_dout[7:0];
  assign pop      = |(dn_wr & dn_ready);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push_ok),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // One-hot valid toward the target named by the head entry
  always_comb begin
    dn_wr = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (!fifo_empty && (head_tgt == TGT_W'(i))) begin
        dn_wr[i] = 1'b1;
      end
    end
  end

  // Occupancy after this cycle, so ioctl_wait rises the cycle after the threshold push
  always_comb begin
    occ_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; a new download window always wins over finishing the drain
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ioctl_download) state_nxt = LOAD;
      LOAD:    if (!ioctl_download) state_nxt = DRAIN;
      DRAIN: begin
        if (ioctl_download)  state_nxt = LOAD;
        else if (fifo_empty) state_nxt = DONE;
      end
      DONE:    state_nxt = ioctl_download ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; a DONE cycle that re-enters LOAD does not count as a finished download
  always_comb begin
    dn_active = (state == LOAD) || (state == DRAIN);
    dn_done   = (state == DONE) && !ioctl_download;
  end

  // Delivery counter, sticky error flags and backpressure
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dn_count   <= '0;
      dn_err     <= '0;
      ioctl_wait <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_nxt == LOAD)) begin
        dn_count <= '0;
        dn_err   <= '0;
      end else begin
        if (pop) begin
          dn_count <= dn_count + 25'd1;
        end
        if (wr_load) begin
          if (!idx_ok) dn_err[ERR_INDEX] <= 1'b1;
          if (!addr_ok) dn_err[ERR_ADDR] <= 1'b1;
          if (idx_ok && addr_ok && !room_ok) dn_err[ERR_OVERFLOW] <= 1'b1;
        end
      end
      ioctl_wait <= (state_nxt == LOAD) && (occ_nxt >= CNT_W'(WAIT_THRESH));
    end
  end

endmodule
